// File: rtl/sprite_tick_scheduler_pkg.sv
// Shared types and constants for the sprite tick scheduler.
package sprite_sched_pkg;

  localparam int PRESCALE_SYN = 249999;
  localparam int PRESCALE_SIM = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  function automatic int ch_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_tick_scheduler_if.sv
// Valid/ready update port between the scheduler and the sprite-position engine.
interface sprite_tick_scheduler_if #(
  parameter int CH_W = 2
) ();
  logic            upd_valid;
  logic [CH_W-1:0] upd_ch;
  logic            upd_ready;

  modport master (output upd_valid, output upd_ch, input upd_ready);
  modport slave  (input upd_valid, input upd_ch, output upd_ready);
endinterface

// File: rtl/sprite_tick_scheduler_rr_pick.sv
// Combinational round-robin search: first set bit of pending at or after rr.
module sched_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [CH_W-1:0]   rr,
  output logic [CH_W-1:0]   idx,
  output logic              found
);

  logic [CH_W-1:0] cand_s;

  // Scan from farthest to nearest so the nearest pending channel wins.
  always_comb begin
    idx    = '0;
    found  = 1'b0;
    cand_s = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand_s = CH_W'((int'(rr) + k) % NUM_CH);
      if (pending[cand_s]) begin
        idx   = cand_s;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/sprite_tick_scheduler.sv
// Shared prescaler, per-channel tick dividers and a round-robin valid/ready
// arbiter that feeds due sprite updates to the position engine.
module sprite_tick_scheduler
  import sprite_sched_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int PRESCALE = PRESCALE_SYN,
  parameter int PERIOD_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       cfg_we,
  input  logic [$clog2(NUM_CH)-1:0]  cfg_ch,
  input  logic [PERIOD_W-1:0]        cfg_period,
  output logic                       base_tick,
  sprite_tick_scheduler_if.master    upd,
  output logic [NUM_CH-1:0]          overrun,
  input  logic                       ovr_clr
);

  localparam int CH_W = ch_width(NUM_CH);
  localparam int PC_W = (PRESCALE < 1) ? 1 : $clog2(PRESCALE + 1);

  logic [PC_W-1:0]     pcnt_r;
  logic                base_tick_r;
  logic [PERIOD_W-1:0] period_r [NUM_CH];
  logic [PERIOD_W-1:0] cnt_r    [NUM_CH];
  logic [NUM_CH-1:0]   pending_r;
  logic [NUM_CH-1:0]   overrun_r;
  logic [NUM_CH-1:0]   wr_hit_s, offer_s, hs_s, fire_s, ovr_set_s;
  arb_state_t          state_r, state_n;
  logic [CH_W-1:0]     upd_ch_r, upd_ch_n, rr_r, rr_n, pick_s;
  logic                found_s;

  // base_tick is registered, so it trails pcnt==PRESCALE by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_r      <= '0;
      base_tick_r <= 1'b0;
    end else if (!enable) begin
      pcnt_r      <= '0;
      base_tick_r <= 1'b0;
    end else if (pcnt_r == PC_W'(PRESCALE)) begin
      pcnt_r      <= '0;
      base_tick_r <= 1'b1;
    end else begin
      pcnt_r      <= pcnt_r + PC_W'(1);
      base_tick_r <= 1'b0;
    end
  end

  always_comb begin
    wr_hit_s  = '0;
    offer_s   = '0;
    hs_s      = '0;
    fire_s    = '0;
    ovr_set_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit_s[i]  = cfg_we && (cfg_ch == CH_W'(i));
      offer_s[i]   = (state_r == OFFER) && (upd_ch_r == CH_W'(i));
      hs_s[i]      = offer_s[i] && upd.upd_ready;
      fire_s[i]    = base_tick_r && (period_r[i] != '0) && (cnt_r[i] == '0) && !wr_hit_s[i];
      ovr_set_s[i] = fire_s[i] && pending_r[i] && !hs_s[i];
    end
  end

  // A same-cycle fire keeps pending set even while its previous tick is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        period_r[i] <= '0;
        cnt_r[i]    <= '0;
      end
      pending_r <= '0;
      overrun_r <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_hit_s[i]) begin
          period_r[i] <= cfg_period;
          cnt_r[i]    <= (cfg_period == '0) ? '0 : cfg_period - PERIOD_W'(1);
        end else if (base_tick_r && (period_r[i] != '0)) begin
          cnt_r[i] <= (cnt_r[i] == '0) ? period_r[i] - PERIOD_W'(1) : cnt_r[i] - PERIOD_W'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end

        if (fire_s[i]) begin
          pending_r[i] <= 1'b1;
        end else if (wr_hit_s[i] && (cfg_period == '0) && !offer_s[i]) begin
          pending_r[i] <= 1'b0;
        end else if (hs_s[i]) begin
          pending_r[i] <= 1'b0;
        end else begin
          pending_r[i] <= pending_r[i];
        end

        if (ovr_set_s[i]) begin
          overrun_r[i] <= 1'b1;
        end else if (ovr_clr) begin
          overrun_r[i] <= 1'b0;
        end else begin
          overrun_r[i] <= overrun_r[i];
        end
      end
    end
  end

  sched_rr_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
    .pending (pending_r),
    .rr      (rr_r),
    .idx     (pick_s),
    .found   (found_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      upd_ch_r <= '0;
      rr_r     <= '0;
    end else begin
      state_r  <= state_n;
      upd_ch_r <= upd_ch_n;
      rr_r     <= rr_n;
    end
  end

  always_comb begin
    state_n  = state_r;
    upd_ch_n = upd_ch_r;
    rr_n     = rr_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          upd_ch_n = pick_s;
          state_n  = OFFER;
        end else begin
          state_n = IDLE;
        end
      end
      OFFER: begin
        if (upd.upd_ready) begin
          state_n = IDLE;
          rr_n    = (upd_ch_r == CH_W'(NUM_CH - 1)) ? '0 : upd_ch_r + CH_W'(1);
        end else begin
          state_n = OFFER;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign base_tick     = base_tick_r;
  assign upd.upd_valid = (state_r == OFFER);
  assign upd.upd_ch    = upd_ch_r;
  assign overrun       = overrun_r;

endmodule

// File: tb/tb_sprite_tick_scheduler.sv
// Randomized and directed bench for sprite_tick_scheduler against a tick-counting reference model.
module tb_sprite_tick_scheduler;

  localparam int NCH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = 2'd0;
  logic [7:0] cfg_period = 8'd0;
  logic       base_tick;
  logic [3:0] overrun;
  logic       ovr_clr = 1'b0;

  int checks = 0;
  int fails  = 0;

  sprite_tick_scheduler_if #(.CH_W(2)) upd_bus ();

  sprite_tick_scheduler #(.NUM_CH(4), .PRESCALE(3), .PERIOD_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .base_tick  (base_tick),
    .upd        (upd_bus),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr)
  );

  always #5 clk = ~clk;

  // Reference model: a phase counter for the prescaler, base ticks counted
  // since each channel's last write, and an offer slot (-1 = none).
  int   m_phase, m_offer, m_rr;
  bit   m_bt;
  int   m_period [NCH];
  int   m_ticks  [NCH];
  bit   m_pend   [NCH];
  logic [3:0] m_ovr;

  task automatic m_reset();
    m_phase = 0; m_offer = -1; m_rr = 0; m_bt = 0; m_ovr = 4'd0;
    for (int i = 0; i < NCH; i++) begin
      m_period[i] = 0; m_ticks[i] = 0; m_pend[i] = 0;
    end
  endtask

  task automatic m_step();
    bit hs, wr, fire, nb;
    int noff;
    if (!rst_n) begin
      m_reset();
      return;
    end
    hs = (m_offer >= 0) && upd_bus.upd_ready;
    noff = m_offer;
    if (m_offer < 0) begin
      for (int k = NCH - 1; k >= 0; k--)
        if (m_pend[(m_rr + k) % NCH]) noff = (m_rr + k) % NCH;
    end else if (upd_bus.upd_ready) begin
      m_rr = (m_offer + 1) % NCH;
      noff = -1;
    end
    for (int i = 0; i < NCH; i++) begin
      wr = cfg_we && (int'(cfg_ch) == i);
      fire = m_bt && !wr && (m_period[i] != 0) && (((m_ticks[i] + 1) % m_period[i]) == 0);
      if (fire && m_pend[i] && !(hs && m_offer == i)) m_ovr[i] = 1'b1;
      else if (ovr_clr) m_ovr[i] = 1'b0;
      if (fire) m_pend[i] = 1;
      else if (wr && cfg_period == 8'd0 && m_offer != i) m_pend[i] = 0;
      else if (hs && m_offer == i) m_pend[i] = 0;
      if (wr) begin
        m_period[i] = int'(cfg_period); m_ticks[i] = 0;
      end else if (m_bt && m_period[i] != 0) begin
        m_ticks[i] = m_ticks[i] + 1;
      end
    end
    m_offer = noff;
    nb = enable && (m_phase == 3);
    m_phase = enable ? ((m_phase + 1) % 4) : 0;
    m_bt = nb;
  endtask

  task automatic cyc();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cfg_we = 1'b0; ovr_clr = 1'b0; upd_bus.upd_ready = 1'b0; enable = 1'b1;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic cfg_write(input int ch, input int p);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_period = 8'(p);
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; upd_bus.upd_ready = 1'b1;
    cyc(); cyc();
    checks++; if (base_tick !== 1'b0) begin fails++; $display("FAIL reset_base_tick got %b want 0", base_tick); end
    checks++; if (upd_bus.upd_valid !== 1'b0) begin fails++; $display("FAIL reset_upd_valid got %b want 0", upd_bus.upd_valid); end
    checks++; if (upd_bus.upd_ch !== 2'd0) begin fails++; $display("FAIL reset_upd_ch got %0d want 0", upd_bus.upd_ch); end
    checks++; if (overrun !== 4'd0) begin fails++; $display("FAIL reset_overrun got %b want 0000", overrun); end
  endtask

  task automatic test_base_tick();
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      cyc();
      checks++; if (base_tick !== ((c % 4) == 0)) begin fails++; $display("FAIL base_tick cycle %0d got %b want %b", c, base_tick, (c % 4) == 0); end
      checks++; if (upd_bus.upd_valid !== 1'b0) begin fails++; $display("FAIL idle_valid cycle %0d got %b want 0", c, upd_bus.upd_valid); end
    end
  endtask

  task automatic test_single_channel();
    int last_bt;
    do_reset();
    upd_bus.upd_ready = 1'b1;
    cfg_write(1, 2);
    last_bt = -100;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (base_tick) last_bt = c;
      checks++; if (base_tick !== m_bt) begin fails++; $display("FAIL single_bt got %b want %b", base_tick, m_bt); end
      checks++; if (upd_bus.upd_valid !== (m_offer >= 0)) begin fails++; $display("FAIL single_valid got %b want %b", upd_bus.upd_valid, m_offer >= 0); end
      if (upd_bus.upd_valid) begin
        checks++; if (upd_bus.upd_ch !== 2'd1) begin fails++; $display("FAIL single_ch got %0d want 1", upd_bus.upd_ch); end
        checks++; if (c - last_bt !== 2) begin fails++; $display("FAIL single_latency got %0d want 2", c - last_bt); end
      end
    end
  endtask

  task automatic test_all_channels();
    int grants[$];
    do_reset();
    upd_bus.upd_ready = 1'b1;
    for (int i = 0; i < NCH; i++) cfg_write(i, 1);
    for (int c = 0; c < 48; c++) begin
      cyc();
      checks++; if (upd_bus.upd_valid !== (m_offer >= 0)) begin fails++; $display("FAIL all_valid got %b want %b", upd_bus.upd_valid, m_offer >= 0); end
      if (m_offer >= 0) begin
        grants.push_back(int'(upd_bus.upd_ch));
        checks++; if (int'(upd_bus.upd_ch) !== m_offer) begin fails++; $display("FAIL all_ch got %0d want %0d", upd_bus.upd_ch, m_offer); end
      end
      checks++; if (overrun !== m_ovr) begin fails++; $display("FAIL all_overrun got %b want %b", overrun, m_ovr); end
    end
    for (int g = 0; g < grants.size(); g++) begin
      checks++; if (grants[g] !== (g % NCH)) begin fails++; $display("FAIL grant_order idx %0d got %0d want %0d", g, grants[g], g % NCH); end
    end
  endtask

  task automatic test_overrun();
    int nbt;
    do_reset();
    cfg_write(2, 1);
    nbt = 0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (m_offer >= 0) begin
        checks++; if (upd_bus.upd_ch !== 2'd2 || upd_bus.upd_valid !== 1'b1) begin fails++; $display("FAIL ovr_hold got v=%b ch=%0d want v=1 ch=2", upd_bus.upd_valid, upd_bus.upd_ch); end
      end
      checks++; if (overrun !== m_ovr) begin fails++; $display("FAIL ovr_flag got %b want %b", overrun, m_ovr); end
      if (nbt == 2) begin
        checks++; if (overrun[2] !== 1'b1) begin fails++; $display("FAIL ovr_second_tick got %b want 1", overrun[2]); end
      end
      if (base_tick) nbt++;
    end
    while (base_tick || m_bt) cyc();
    ovr_clr = 1'b1;
    cyc();
    ovr_clr = 1'b0;
    checks++; if (overrun !== 4'd0) begin fails++; $display("FAIL ovr_clear got %b want 0000", overrun); end
    checks++; if (overrun !== m_ovr) begin fails++; $display("FAIL ovr_clear_model got %b want %b", overrun, m_ovr); end
  endtask

  task automatic test_disable_pending();
    int budget;
    do_reset();
    cfg_write(0, 1);
    cfg_write(3, 1);
    budget = 0;
    while (!(m_offer == 0 && m_pend[3]) && budget < 40) begin cyc(); budget++; end
    checks++; if (budget >= 40) begin fails++; $display("FAIL dis_setup timeout got %0d want <40", budget); end
    cfg_write(3, 0);
    upd_bus.upd_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      cyc();
      checks++; if (upd_bus.upd_valid && upd_bus.upd_ch === 2'd3) begin fails++; $display("FAIL dis_ch3_offer got ch=3 want none"); end
      checks++; if (upd_bus.upd_valid !== (m_offer >= 0)) begin fails++; $display("FAIL dis_valid got %b want %b", upd_bus.upd_valid, m_offer >= 0); end
    end
  endtask

  task automatic test_enable_off_drain();
    do_reset();
    for (int i = 0; i < NCH; i++) cfg_write(i, 1);
    while (!m_bt) cyc();
    enable = 1'b0;
    upd_bus.upd_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      cyc();
      checks++; if (base_tick !== 1'b0) begin fails++; $display("FAIL drain_bt got %b want 0", base_tick); end
      checks++; if (upd_bus.upd_valid !== (m_offer >= 0)) begin fails++; $display("FAIL drain_valid got %b want %b", upd_bus.upd_valid, m_offer >= 0); end
      if (m_offer >= 0) begin
        checks++; if (int'(upd_bus.upd_ch) !== m_offer) begin fails++; $display("FAIL drain_ch got %0d want %0d", upd_bus.upd_ch, m_offer); end
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      enable = ($urandom_range(0, 9) != 0);
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_ch = 2'($urandom_range(0, 3));
      cfg_period = 8'($urandom_range(0, 3));
      upd_bus.upd_ready = $urandom_range(0, 1) != 0;
      ovr_clr = ($urandom_range(0, 15) == 0);
      cyc();
      checks++; if (base_tick !== m_bt) begin fails++; $display("FAIL rnd_bt cycle %0d got %b want %b", c, base_tick, m_bt); end
      checks++; if (upd_bus.upd_valid !== (m_offer >= 0)) begin fails++; $display("FAIL rnd_valid cycle %0d got %b want %b", c, upd_bus.upd_valid, m_offer >= 0); end
      if (m_offer >= 0) begin
        checks++; if (int'(upd_bus.upd_ch) !== m_offer) begin fails++; $display("FAIL rnd_ch cycle %0d got %0d want %0d", c, upd_bus.upd_ch, m_offer); end
      end
      checks++; if (overrun !== m_ovr) begin fails++; $display("FAIL rnd_overrun cycle %0d got %b want %b", c, overrun, m_ovr); end
    end
    cfg_we = 1'b0; ovr_clr = 1'b0; enable = 1'b1;
  endtask

  task automatic test_mid_reset();
    int budget, first_bt;
    do_reset();
    cfg_write(0, 1);
    budget = 0;
    while (m_offer < 0 && budget < 20) begin cyc(); budget++; end
    checks++; if (upd_bus.upd_valid !== 1'b1) begin fails++; $display("FAIL mrst_offer got %b want 1", upd_bus.upd_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (upd_bus.upd_valid !== 1'b0) begin fails++; $display("FAIL mrst_valid_drop got %b want 0", upd_bus.upd_valid); end
    cyc();
    rst_n = 1'b1;
    first_bt = 0;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      if (base_tick && first_bt == 0) first_bt = c;
      checks++; if (upd_bus.upd_valid !== 1'b0) begin fails++; $display("FAIL mrst_no_offer got %b want 0", upd_bus.upd_valid); end
    end
    checks++; if (first_bt !== 4) begin fails++; $display("FAIL mrst_first_tick got %0d want 4", first_bt); end
  endtask

  initial begin
    upd_bus.upd_ready = 1'b0;
    m_reset();
    test_reset();
    test_base_tick();
    test_single_channel();
    test_all_channels();
    test_overrun();
    test_disable_pending();
    test_enable_off_drain();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
